bitwise_logic_unit: RTL

BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

---
 rtl/bitwise_logic_unit_pkg.sv | 17 +
 rtl/bitwise_logic_unit_if.sv | 30 +++
 rtl/bitwise_logic_unit_op.sv | 28 ++
 rtl/bitwise_logic_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/bitwise_logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: operation encoding and select width.
package bitwise_logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Operand/result bus of the bitwise logic unit with valid/ready handshakes on both sides.
interface bitwise_logic_unit_if #(
  parameter int unsigned WIDTH = 8
);
  import bitwise_logic_unit_pkg::*;

  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [OP_W-1:0]  Op;
  logic             Acc;
  logic             AccClr;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] Out;
  logic             OutValid;
  logic             OutReady;
  logic             OutZero;
  logic             OutParity;

  modport master (
    output In1, In2, Op, Acc, AccClr, InValid, OutReady,
    input  InReady, Out, OutValid, OutZero, OutParity
  );

  modport slave (
    input  In1, In2, Op, Acc, AccClr, InValid, OutReady,
    output InReady, Out, OutValid, OutZero, OutParity
  );

endinterface

// File: rtl/bitwise_logic_unit_op.sv
// Combinational bitwise operation Op(A,B) over WIDTH bits; NOT/PASS use A only.
module bitwise_op
  import bitwise_logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage bitwise logic pipeline with optional accumulator feedback in place of operand B.
module bitwise_logic_unit
  import bitwise_logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  bitwise_logic_unit_if.slave bus
);

  logic             s2_adv;
  logic             s1_adv;
  logic             in_ready;
  logic             in_xfer;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] s1_res_new;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_res_q, s1_res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_zero_q, out_zero_d;
  logic             out_parity_q, out_parity_d;

  always_comb begin
    s2_adv     = ~out_valid_q | bus.OutReady;
    s1_adv     = ~s1_valid_q | s2_adv;
    in_ready   = Rst_n & s1_adv;
    in_xfer    = bus.InValid & in_ready;
    op_b       = bus.Acc ? acc_q : bus.In2;
    s1_res_new = (bus.Acc & bus.AccClr) ? bus.In1 : op_y;
  end

  bitwise_op #(
    .WIDTH(WIDTH)
  ) u_op (
    .a (bus.In1),
    .b (op_b),
    .op(bus.Op),
    .y (op_y)
  );

  // Accumulator is written on the transfer edge, so the next word already sees it.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_res_d     = s1_res_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_zero_d   = out_zero_q;
    out_parity_d = out_parity_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d        = s1_res_q;
        out_zero_d   = ~|s1_res_q;
        out_parity_d = ^s1_res_q;
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_xfer;
      if (in_xfer) s1_res_d = s1_res_new;
    end
    if (in_xfer && bus.Acc) acc_d = s1_res_new;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_res_q     <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_zero_q   <= 1'b1;
      out_parity_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_res_q     <= s1_res_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_zero_q   <= out_zero_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign bus.InReady   = in_ready;
  assign bus.Out       = out_q;
  assign bus.OutValid  = out_valid_q;
  assign bus.OutZero   = out_zero_q;
  assign bus.OutParity = out_parity_q;

endmodule
